// File: rtl/sprite_pkg.sv
// Shared types, colour constants and bitmap content for the animated sprite.
// Pure definitions: no logic, no latency, no flow control.
package sprite_pkg;

    typedef logic [7:0] rgb_t;

    localparam rgb_t TRANSPARENT_ENCODING = 8'hFF;
    localparam int   DEFAULT_WIDTH_X      = 32;
    localparam int   DEFAULT_HEIGHT_Y     = 32;

    // Pixels on the diagonal are see-through; all others are even, so never collide with 8'hFF.
    function automatic rgb_t sprite_pixel(input int f, input int y, input int x);
        int v;
        if (x == y) begin
            return TRANSPARENT_ENCODING;
        end
        v = f * 64 + x * 8 + y * 2;
        return v[7:0];
    endfunction

endpackage

// File: rtl/sprite_frame_sequencer.sv
// Hold-timer and animation frame counter, stepped by startOfFrame while animEnable is high.
// Frame index updates on the clock of the qualifying pulse; no backpressure.
module sprite_frame_sequencer
    import sprite_pkg::*;
#(
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_HOLD = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       animEnable,
    output logic [2:0] frameIndex
);

    localparam int         HOLD_W     = (FRAME_HOLD > 0) ? $clog2(FRAME_HOLD + 1) : 1;
    localparam logic [2:0] LAST_FRAME = 3'(NUM_FRAMES - 1);

    logic [HOLD_W-1:0] holdTimer;

    always_ff @(posedge clk) begin
        if (reset) begin
            holdTimer  <= HOLD_W'(FRAME_HOLD);
            frameIndex <= 3'd0;
        end else if (startOfFrame && animEnable) begin
            if (holdTimer != '0) begin
                holdTimer <= holdTimer - HOLD_W'(1);
            end else begin
                holdTimer  <= HOLD_W'(FRAME_HOLD);
                frameIndex <= (frameIndex == LAST_FRAME) ? 3'd0 : frameIndex + 3'd1;
            end
        end
    end

endmodule

// File: rtl/sprite_anim_bitmap.sv
// Animated sprite bitmap lookup: 2-clock pipeline (address/valid, then ROM read), 1 pixel/clk.
// No backpressure; frameIndex is the live counter, pixels use the frame captured at stage 1.
module sprite_anim_bitmap
    import sprite_pkg::*;
#(
    parameter int OBJECT_WIDTH_X  = DEFAULT_WIDTH_X,
    parameter int OBJECT_HEIGHT_Y = DEFAULT_HEIGHT_Y,
    parameter int NUM_FRAMES      = 4,
    parameter int FRAME_HOLD      = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] offsetX,
    input  logic [10:0] offsetY,
    input  logic        insideRectangle,
    input  logic        startOfFrame,
    input  logic        animEnable,
    output logic        drawingRequest,
    output logic [7:0]  RGBout,
    output logic [2:0]  frameIndex
);

    localparam int              FRAME_PIXELS = OBJECT_HEIGHT_Y * OBJECT_WIDTH_X;
    localparam int              ROM_DEPTH    = NUM_FRAMES * FRAME_PIXELS;
    localparam int              ADDR_W       = $clog2(ROM_DEPTH);
    localparam logic [10:0]     X_LIM        = 11'(OBJECT_WIDTH_X);
    localparam logic [10:0]     Y_LIM        = 11'(OBJECT_HEIGHT_Y);
    localparam logic [ADDR_W:0] DEPTH_LIM    = (ADDR_W + 1)'(ROM_DEPTH);

    sprite_frame_sequencer #(
        .NUM_FRAMES (NUM_FRAMES),
        .FRAME_HOLD (FRAME_HOLD)
    ) u_seq (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .animEnable   (animEnable),
        .frameIndex   (frameIndex)
    );

    rgb_t bitmap [ROM_DEPTH];

    for (genvar a = 0; a < ROM_DEPTH; a++) begin : g_rom
        assign bitmap[a] = sprite_pixel(a / FRAME_PIXELS, (a / OBJECT_WIDTH_X) % OBJECT_HEIGHT_Y,
                                        a % OBJECT_WIDTH_X);
    end

    logic        s1_valid;
    logic [2:0]  s1_frame;
    logic [10:0] s1_y;
    logic [10:0] s1_x;

    // The frame is sampled here so a same-cycle advance only affects later pixels.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= insideRectangle && (offsetX < X_LIM) && (offsetY < Y_LIM);
        end
        s1_frame <= frameIndex;
        s1_y     <= offsetY;
        s1_x     <= offsetX;
    end

    logic [ADDR_W-1:0] rom_addr;
    rgb_t              pixel;

    assign rom_addr = ADDR_W'(s1_frame) * ADDR_W'(FRAME_PIXELS)
                    + ADDR_W'(s1_y) * ADDR_W'(OBJECT_WIDTH_X)
                    + ADDR_W'(s1_x);
    assign pixel    = ({1'b0, rom_addr} < DEPTH_LIM) ? bitmap[rom_addr] : TRANSPARENT_ENCODING;

    always_ff @(posedge clk) begin
        if (reset) begin
            RGBout         <= TRANSPARENT_ENCODING;
            drawingRequest <= 1'b0;
        end else if (s1_valid) begin
            RGBout         <= pixel;
            drawingRequest <= (pixel != TRANSPARENT_ENCODING);
        end else begin
            RGBout         <= TRANSPARENT_ENCODING;
            drawingRequest <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sprite_anim_bitmap.sv
// Directed bench for sprite_anim_bitmap: frame sequencing, 2-clock pixel pipeline, reset flush.
module tb_sprite_anim_bitmap;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        insideRectangle;
    logic        startOfFrame;
    logic        animEnable;
    logic        drawingRequest;
    logic [7:0]  RGBout;
    logic [2:0]  frameIndex;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sprite_anim_bitmap dut (
        .clk             (clk),
        .reset           (reset),
        .offsetX         (offsetX),
        .offsetY         (offsetY),
        .insideRectangle (insideRectangle),
        .startOfFrame    (startOfFrame),
        .animEnable      (animEnable),
        .drawingRequest  (drawingRequest),
        .RGBout          (RGBout),
        .frameIndex      (frameIndex)
    );

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        insideRectangle = 1'b0;
        startOfFrame = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulses(input int n, input logic en);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            startOfFrame = 1'b1;
            animEnable = en;
            @(negedge clk);
            startOfFrame = 1'b0;
        end
    endtask

    task automatic test_reset();
        // Reset held together with a frame pulse and a valid pixel: reset must win.
        @(negedge clk);
        reset = 1'b1;
        startOfFrame = 1'b1;
        animEnable = 1'b1;
        insideRectangle = 1'b1;
        offsetX = 11'd3;
        offsetY = 11'd2;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        startOfFrame = 1'b0;
        insideRectangle = 1'b0;
        vectors++;
        if (frameIndex !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_frame: got %0d want 0", frameIndex);
        end
        vectors++;
        if (drawingRequest !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_draw: got %b want 0", drawingRequest);
        end
        vectors++;
        if (RGBout !== 8'hFF) begin
            miscompares++;
            $display("FAIL reset_rgb: got %h want ff", RGBout);
        end
    endtask

    task automatic test_frame_advance();
        apply_reset();
        pulses(5, 1'b1);
        vectors++;
        if (frameIndex !== 3'd0) begin
            miscompares++;
            $display("FAIL adv_after5: got %0d want 0", frameIndex);
        end
        pulses(1, 1'b1);
        vectors++;
        if (frameIndex !== 3'd1) begin
            miscompares++;
            $display("FAIL adv_after6: got %0d want 1", frameIndex);
        end
        pulses(12, 1'b1);
        vectors++;
        if (frameIndex !== 3'd3) begin
            miscompares++;
            $display("FAIL adv_after18: got %0d want 3", frameIndex);
        end
        pulses(5, 1'b1);
        vectors++;
        if (frameIndex !== 3'd3) begin
            miscompares++;
            $display("FAIL adv_after23: got %0d want 3", frameIndex);
        end
        pulses(1, 1'b1);
        vectors++;
        if (frameIndex !== 3'd0) begin
            miscompares++;
            $display("FAIL adv_wrap24: got %0d want 0", frameIndex);
        end
    endtask

    task automatic test_pause();
        apply_reset();
        pulses(3, 1'b1);
        pulses(10, 1'b0);
        vectors++;
        if (frameIndex !== 3'd0) begin
            miscompares++;
            $display("FAIL pause_frozen: got %0d want 0", frameIndex);
        end
        pulses(2, 1'b1);
        vectors++;
        if (frameIndex !== 3'd0) begin
            miscompares++;
            $display("FAIL pause_resume2: got %0d want 0", frameIndex);
        end
        pulses(1, 1'b1);
        vectors++;
        if (frameIndex !== 3'd1) begin
            miscompares++;
            $display("FAIL pause_resume3: got %0d want 1", frameIndex);
        end
    endtask

    task automatic test_pixel_latency();
        apply_reset();
        @(negedge clk);
        insideRectangle = 1'b1;
        offsetX = 11'd3;
        offsetY = 11'd2;
        @(negedge clk);
        insideRectangle = 1'b0;
        vectors++;
        if (drawingRequest !== 1'b0 || RGBout !== 8'hFF) begin
            miscompares++;
            $display("FAIL lat_1clk: got dr=%b rgb=%h want dr=0 rgb=ff", drawingRequest, RGBout);
        end
        @(negedge clk);
        vectors++;
        if (drawingRequest !== 1'b1 || RGBout !== 8'h1C) begin
            miscompares++;
            $display("FAIL lat_2clk: got dr=%b rgb=%h want dr=1 rgb=1c", drawingRequest, RGBout);
        end
        @(negedge clk);
        vectors++;
        if (drawingRequest !== 1'b0 || RGBout !== 8'hFF) begin
            miscompares++;
            $display("FAIL lat_3clk: got dr=%b rgb=%h want dr=0 rgb=ff", drawingRequest, RGBout);
        end
    endtask

    // One pixel per clock; each output is checked two clocks after its input.
    task automatic test_back_to_back();
        localparam int N = 11;
        logic [10:0] vx [N]  = '{11'd1, 11'd0, 11'd31, 11'd0,  11'd31, 11'd3, 11'd40, 11'd3,  11'd3, 11'd2,  11'd5};
        logic [10:0] vy [N]  = '{11'd0, 11'd1, 11'd0,  11'd31, 11'd31, 11'd2, 11'd2,  11'd32, 11'd2, 11'd3,  11'd5};
        logic        vin [N] = '{1'b1,  1'b1,  1'b1,   1'b1,   1'b1,   1'b1,  1'b1,   1'b1,   1'b0,  1'b1,   1'b1};
        logic [7:0]  ergb [N] = '{8'h08, 8'h02, 8'hF8, 8'h3E, 8'hFF, 8'h1C, 8'hFF, 8'hFF, 8'hFF, 8'h16, 8'hFF};
        logic        edr [N]  = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0};
        apply_reset();
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                vectors++;
                if (RGBout !== ergb[i-2] || drawingRequest !== edr[i-2]) begin
                    miscompares++;
                    $display("FAIL stream[%0d] x=%0d y=%0d: got dr=%b rgb=%h want dr=%b rgb=%h",
                             i - 2, vx[i-2], vy[i-2], drawingRequest, RGBout, edr[i-2], ergb[i-2]);
                end
            end
            if (i < N) begin
                offsetX = vx[i];
                offsetY = vy[i];
                insideRectangle = vin[i];
            end else begin
                insideRectangle = 1'b0;
            end
        end
    endtask

    task automatic test_frame_boundary();
        apply_reset();
        pulses(5, 1'b1);
        @(negedge clk);
        startOfFrame = 1'b1;
        animEnable = 1'b1;
        insideRectangle = 1'b1;
        offsetX = 11'd3;
        offsetY = 11'd2;
        @(negedge clk);
        startOfFrame = 1'b0;
        @(negedge clk);
        insideRectangle = 1'b0;
        vectors++;
        if (drawingRequest !== 1'b1 || RGBout !== 8'h1C) begin
            miscompares++;
            $display("FAIL boundary_old: got dr=%b rgb=%h want dr=1 rgb=1c", drawingRequest, RGBout);
        end
        @(negedge clk);
        vectors++;
        if (drawingRequest !== 1'b1 || RGBout !== 8'h5C) begin
            miscompares++;
            $display("FAIL boundary_new: got dr=%b rgb=%h want dr=1 rgb=5c", drawingRequest, RGBout);
        end
        vectors++;
        if (frameIndex !== 3'd1) begin
            miscompares++;
            $display("FAIL boundary_frame: got %0d want 1", frameIndex);
        end
    endtask

    task automatic test_reset_flush();
        apply_reset();
        pulses(6, 1'b1);
        vectors++;
        if (frameIndex !== 3'd1) begin
            miscompares++;
            $display("FAIL flush_pre_frame: got %0d want 1", frameIndex);
        end
        @(negedge clk);
        insideRectangle = 1'b1;
        offsetX = 11'd1;
        offsetY = 11'd0;
        @(negedge clk);
        offsetX = 11'd2;
        offsetY = 11'd3;
        @(negedge clk);
        reset = 1'b1;
        offsetX = 11'd3;
        offsetY = 11'd2;
        @(negedge clk);
        reset = 1'b0;
        insideRectangle = 1'b0;
        vectors++;
        if (drawingRequest !== 1'b0 || RGBout !== 8'hFF || frameIndex !== 3'd0) begin
            miscompares++;
            $display("FAIL flush_out1: got dr=%b rgb=%h fi=%0d want dr=0 rgb=ff fi=0",
                     drawingRequest, RGBout, frameIndex);
        end
        @(negedge clk);
        vectors++;
        if (drawingRequest !== 1'b0 || RGBout !== 8'hFF || frameIndex !== 3'd0) begin
            miscompares++;
            $display("FAIL flush_out2: got dr=%b rgb=%h fi=%0d want dr=0 rgb=ff fi=0",
                     drawingRequest, RGBout, frameIndex);
        end
    endtask

    initial begin
        reset = 1'b1;
        offsetX = 11'd0;
        offsetY = 11'd0;
        insideRectangle = 1'b0;
        startOfFrame = 1'b0;
        animEnable = 1'b1;
        test_reset();
        test_frame_advance();
        test_pause();
        test_pixel_latency();
        test_back_to_back();
        test_frame_boundary();
        test_reset_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sprite_anim_bitmap.md
SPRITE_ANIM_BITMAP -- requirements
Module: sprite_anim_bitmap

Interface
REQ-001 SHALL have parameter OBJECT_WIDTH_X, default 32, sprite width in pixels.
REQ-002 SHALL have parameter OBJECT_HEIGHT_Y, default 32, sprite height in pixels.
REQ-003 SHALL have parameter NUM_FRAMES, default 4, number of animation frames (power of 2, at most 8).
REQ-004 SHALL have parameter FRAME_HOLD, default 5, number of startOfFrame pulses each frame is held, minus one.
REQ-005 SHALL have port clk  in  1  the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port offsetX  in  11  pixel column inside the sprite, taken from the upstream flip stage (already mirrored).
REQ-008 SHALL have port offsetY  in  11  pixel row inside the sprite.
REQ-009 SHALL have port insideRectangle  in  1  high when the current pixel lies in the object rectangle.
REQ-010 SHALL have port startOfFrame  in  1  one-cycle pulse at the start of each video frame.
REQ-011 SHALL have port animEnable  in  1  high lets the animation advance; low freezes it.
REQ-012 SHALL have port drawingRequest  out  1  high when the sprite pixel is opaque and must be drawn.
REQ-013 SHALL have port RGBout  out  8  pixel colour in RRRGGGBB format.
REQ-014 SHALL have port frameIndex  out  3  current animation frame, for debug and for the collision logic.

Function
REQ-015 SHALL keep holdTimer and frameIndex state; they change only in cycles where startOfFrame=1 and animEnable=1.
REQ-016 In such a cycle, if holdTimer>0 the block SHALL decrement holdTimer; otherwise it SHALL reload holdTimer to FRAME_HOLD and advance frameIndex by 1.
REQ-017 frameIndex SHALL wrap from NUM_FRAMES-1 to 0.
REQ-018 startOfFrame while animEnable=0 SHALL leave holdTimer and frameIndex unchanged; when animEnable is raised again, counting SHALL resume from the held values.
REQ-019 Pipeline stage 1 SHALL register the bitmap address {frameIndex, offsetY, offsetX} and a valid bit.
REQ-020 The stage-1 valid bit SHALL be insideRectangle && offsetX<OBJECT_WIDTH_X && offsetY<OBJECT_HEIGHT_Y; any out-of-range offset SHALL be treated as outside.
REQ-021 Pipeline stage 2 SHALL read the bitmap array at the stage-1 address and register the result as RGBout.
REQ-022 Latency SHALL be exactly 2 clocks from inputs to RGBout/drawingRequest, with throughput of 1 pixel per clock.
REQ-023 drawingRequest SHALL equal stage-1 valid && pixel != TRANSPARENT_ENCODING, registered in the same stage as RGBout.
REQ-024 When not valid, RGBout SHALL be TRANSPARENT_ENCODING and drawingRequest SHALL be 0.
REQ-025 A pixel already in the pipeline SHALL use the frameIndex captured at stage 1, even if the frame advances in the same cycle.
REQ-026 The frameIndex output SHALL be the live counter value, not the pipelined value.

Reset
REQ-027 While reset=1 at a clock edge, the block SHALL set frameIndex=0, holdTimer=FRAME_HOLD, both valid bits=0, drawingRequest=0 and RGBout=TRANSPARENT_ENCODING.
REQ-028 Reset SHALL take priority over a simultaneous startOfFrame.
REQ-029 Reset asserted mid-frame SHALL flush in-flight pixels: no drawingRequest for 2 cycles after reset is released unless new valid inputs arrive.

Structure
REQ-030 Package sprite_pkg SHALL hold: typedef rgb_t (8 bits), constant TRANSPARENT_ENCODING=8'hFF, and the default sprite dimensions.
REQ-031 The hold-timer and frame counter SHALL be a sub-module, sprite_frame_sequencer, with ports clk, reset, startOfFrame, animEnable and frameIndex.
REQ-032 The bitmap SHALL be a constant array of NUM_FRAMES x OBJECT_HEIGHT_Y x OBJECT_WIDTH_X rgb_t entries, local to the module and synthesised as ROM.

Verification
REQ-033 Reset, then 6 startOfFrame pulses with animEnable=1 -> frameIndex goes 0 to 1 on the 6th pulse; after 24 pulses it is back at 0.
REQ-034 animEnable=0 during 10 pulses, then 1 -> frameIndex and holdTimer unchanged across the pause, and the advance occurs after the remaining count.
REQ-035 insideRectangle=1, offset (3,2), opaque entry 8'h1C -> RGBout=8'h1C and drawingRequest=1 exactly 2 clocks later.
REQ-036 offsetX=40 with insideRectangle=1 -> drawingRequest=0 and RGBout=8'hFF after 2 clocks; a transparent entry at an in-range offset gives the same result.
REQ-037 startOfFrame advances the frame in the same cycle a pixel enters stage 1 -> that pixel shows old-frame data and the next pixel shows new-frame data.
REQ-038 reset pulsed while the pipeline is full -> the next 2 outputs are drawingRequest=0 and RGBout=8'hFF, with frameIndex=0.
